// File: rtl/ram_req_ctrl.sv
// RAM request controller: read/write requests, 2-deep read response FIFO,
// and a whole-memory fill engine that owns the RAM port while busy.
//
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_req_*, o_req_ready  request channel (valid/ready, we, addr, wdata)
//   i_fill_start/_data    one-cycle fill trigger and fill value
//   o_busy                high while the fill runs
//   o_ram_*, i_ram_rdata  RAM port (registered read data, 1-cycle latency)
//   o_rsp_*, i_rsp_ready  read response channel (valid/ready, data)
module ram_req_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    input  logic                  i_fill_start,
    input  logic [DATA_WIDTH-1:0] i_fill_data,
    output logic                  o_busy,
    output logic                  o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_wdata,
    input  logic [DATA_WIDTH-1:0] i_ram_rdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_data
);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] CNT_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   fill_q, fill_d;
    logic                    pend_q, pend_d;
    logic [DATA_WIDTH-1:0]   mem_q [2];
    logic [DATA_WIDTH-1:0]   mem_d [2];
    logic                    rd_ptr_q, rd_ptr_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic [1:0]              count_q, count_d;

    logic                    pop;
    logic                    push;
    logic [2:0]              occ;
    logic                    room;
    logic                    accept;

    always_comb begin
        pop  = (count_q != 2'd0) & i_rsp_ready;
        push = pend_q;
        // Entries held plus the read whose data lands next edge, minus
        // the entry leaving this cycle, must leave space for one more.
        occ  = {1'b0, count_q} + {2'b00, pend_q};
        room = occ < (3'd2 + {2'b00, pop});

        o_req_ready = i_rst_n & (state_q == IDLE) & ~i_fill_start & room;
        accept      = i_req_valid & o_req_ready;

        o_busy      = (state_q == FILL);
        o_rsp_valid = (count_q != 2'd0);
        o_rsp_data  = mem_q[rd_ptr_q];

        o_ram_we    = 1'b0;
        o_ram_addr  = '0;
        o_ram_wdata = '0;
        if (state_q == FILL) begin
            o_ram_we    = 1'b1;
            o_ram_addr  = cnt_q;
            o_ram_wdata = fill_q;
        end else if (accept) begin
            o_ram_we    = i_req_we;
            o_ram_addr  = i_req_addr;
            o_ram_wdata = i_req_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        unique case (state_q)
            IDLE: begin
                if (i_fill_start) begin
                    state_d = FILL;
                    cnt_d   = '0;
                    fill_d  = i_fill_data;
                end
            end
            FILL: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pend_d   = accept & ~i_req_we;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        // Read data is captured unconditionally; the ready rule above
        // guarantees a free slot whenever pend_q is set.
        if (push) begin
            mem_d[wr_ptr_q] = i_ram_rdata;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            fill_q   <= '0;
            pend_q   <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fill_q   <= fill_d;
            pend_q   <= pend_d;
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
